// File: rtl/sub_sample_serializer.sv
// Captures {stage3, seq, counter, complex_result} samples into a small FIFO and
// replays each one as a 6-byte valid/ready frame for per-instance tracing.
module sub_sample_serializer #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 8,
    parameter int RES_W = 32
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    input  logic                       in_stage3,
    input  logic [CNT_W-1:0]           in_counter,
    input  logic [RES_W-1:0]           in_result,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [7:0]                 out_data,
    output logic                       out_last,
    output logic [7:0]                 drop_cnt,
    output logic [$clog2(DEPTH):0]     fifo_level
);

    localparam int PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int LVL_W   = $clog2(DEPTH) + 1;
    localparam int FRAME_W = 8 + CNT_W + RES_W;
    localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);
    localparam logic [2:0]       LAST_IDX = 3'd5;

    typedef enum logic {IDLE, SEND} state_t;

    state_t               state_q, state_d;
    logic [2:0]           byte_idx_q;
    logic [PTR_W-1:0]     wr_ptr_q, rd_ptr_q;
    logic [LVL_W-1:0]     level_q;
    logic [6:0]           seq_q;
    logic [7:0]           drop_q;
    logic [FRAME_W-1:0]   mem [DEPTH];
    logic [FRAME_W-1:0]   frame_p1;

    logic pop, full, push_ok, drop, hs;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    // A pop frees a slot on the same edge, so a full FIFO still accepts then.
    assign pop     = (state_q == IDLE) && (level_q != '0);
    assign full    = (level_q == FULL_LVL);
    assign push_ok = in_valid && (!full || pop);
    assign drop    = in_valid && full && !pop;
    assign hs      = (state_q == SEND) && out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (level_q != '0) state_d = SEND;
            SEND: if (hs && byte_idx_q == LAST_IDX) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        out_valid = (state_q == SEND);
        out_data  = (state_q == SEND) ? frame_p1[FRAME_W-1 -: 8] : 8'h00;
        out_last  = (state_q == SEND) && (byte_idx_q == LAST_IDX);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            byte_idx_q <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            seq_q      <= '0;
            drop_q     <= '0;
        end else begin
            if (pop) begin
                byte_idx_q <= '0;
            end else if (hs && byte_idx_q != LAST_IDX) begin
                byte_idx_q <= byte_idx_q + 3'd1;
            end
            if (push_ok) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
                seq_q    <= seq_q + 7'd1;
            end
            if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
            if (drop) drop_q <= sat_inc8(drop_q);
            unique case ({push_ok, pop})
                2'b10:   level_q <= level_q + 1'b1;
                2'b01:   level_q <= level_q - 1'b1;
                default: level_q <= level_q;
            endcase
        end
    end

    // Stage p1: frame shift register, most significant byte goes out first
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr_q] <= {in_stage3, seq_q, in_counter, in_result};
        if (pop) begin
            frame_p1 <= mem[rd_ptr_q];
        end else if (hs) begin
            frame_p1 <= frame_p1 << 8;
        end
    end

    assign drop_cnt   = drop_q;
    assign fifo_level = level_q;

endmodule

// File: tb/tb_sub_sample_serializer.sv
// Scoreboard bench for sub_sample_serializer: expected frame bytes are queued
// when samples are driven and checked at every output handshake.
module tb_sub_sample_serializer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_stage3;
    logic [7:0]  in_counter;
    logic [31:0] in_result;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [7:0]  out_data;
    logic        out_last;
    logic [7:0]  drop_cnt;
    logic [2:0]  fifo_level;

    int checks = 0;
    int errors = 0;
    int hs_cnt = 0;
    logic [8:0] sb [$];

    sub_sample_serializer #(.DEPTH(4), .CNT_W(8), .RES_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_stage3(in_stage3),
        .in_counter(in_counter), .in_result(in_result), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
        .drop_cnt(drop_cnt), .fifo_level(fifo_level)
    );

    always #5 clk = ~clk;

    // Handshake consumer: values are stable at negedge and accepted at the next posedge.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            logic [8:0] exp;
            hs_cnt = hs_cnt + 1;
            checks = checks + 1;
            if (sb.size() == 0) begin
                errors = errors + 1;
                $display("FAIL sb_extra_byte: got last=%0b data=%02h, expected no byte", out_last, out_data);
            end else begin
                exp = sb.pop_front();
                if ({out_last, out_data} !== exp) begin
                    errors = errors + 1;
                    $display("FAIL sb_byte: got last=%0b data=%02h, expected last=%0b data=%02h",
                             out_last, out_data, exp[8], exp[7:0]);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        in_valid   = 1'b0;
        in_stage3  = 1'bx;
        in_counter = 'x;
        in_result  = 'x;
    endtask

    task automatic drive_sample(input logic st3, input logic [7:0] cnt, input logic [31:0] res);
        in_valid   = 1'b1;
        in_stage3  = st3;
        in_counter = cnt;
        in_result  = res;
    endtask

    task automatic push_frame(input logic [6:0] seq, input logic st3, input logic [7:0] cnt,
                              input logic [31:0] res);
        sb.push_back({1'b0, st3, seq});
        sb.push_back({1'b0, cnt});
        sb.push_back({1'b0, res[31:24]});
        sb.push_back({1'b0, res[23:16]});
        sb.push_back({1'b0, res[15:8]});
        sb.push_back({1'b1, res[7:0]});
    endtask

    task automatic apply_reset();
        idle_inputs();
        out_ready = 1'b0;
        rst_n = 1'b0;
        sb.delete();
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic wait_drain(input int budget, input string name);
        int i;
        for (i = 0; i < budget; i++) begin
            if (sb.size() == 0 && !out_valid && fifo_level == 3'd0) break;
            tick();
        end
        checks++;
        if (i == budget) begin
            errors++;
            $display("FAIL %s_drain: %0d bytes still expected, out_valid=%0b level=%0d after %0d cycles",
                     name, sb.size(), out_valid, fifo_level, budget);
        end
    endtask

    task automatic test_reset();
        idle_inputs();
        #1 rst_n = 1'b0;
        #3;
        checks++;
        if ({out_valid, out_data, out_last, drop_cnt, fifo_level} !== 20'h0) begin
            errors++;
            $display("FAIL reset_outputs: got valid=%0b data=%02h last=%0b drop=%0d level=%0d, expected all 0",
                     out_valid, out_data, out_last, drop_cnt, fifo_level);
        end
        tick();
        rst_n = 1'b1;
        tick();
        checks++;
        if ({out_valid, drop_cnt, fifo_level} !== 12'h0) begin
            errors++;
            $display("FAIL reset_release: got valid=%0b drop=%0d level=%0d, expected 0",
                     out_valid, drop_cnt, fifo_level);
        end
    endtask

    task automatic test_single();
        apply_reset();
        out_ready = 1'b1;
        drive_sample(1'b1, 8'h12, 32'hDEADBEEF);
        push_frame(7'd0, 1'b1, 8'h12, 32'hDEADBEEF);
        tick();
        idle_inputs();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL single_latency_early: out_valid=%0b one cycle after capture, expected 0", out_valid);
        end
        tick();
        checks++;
        if (out_valid !== 1'b1 || out_data !== 8'h80) begin
            errors++;
            $display("FAIL single_first_byte: valid=%0b data=%02h, expected valid=1 data=80", out_valid, out_data);
        end
        wait_drain(40, "single");
    endtask

    task automatic test_backpressure();
        bit pattern [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        bit prev_stall = 1'b0;
        logic [8:0] prev = '0;
        int base;
        int i;
        apply_reset();
        base = hs_cnt;
        drive_sample(1'b1, 8'h12, 32'hDEADBEEF);
        push_frame(7'd0, 1'b1, 8'h12, 32'hDEADBEEF);
        tick();
        idle_inputs();
        for (i = 0; i < 60; i++) begin
            tick();
            if (prev_stall) begin
                checks++;
                if (!out_valid || {out_last, out_data} !== prev) begin
                    errors++;
                    $display("FAIL bp_stable: valid=%0b last=%0b data=%02h, expected valid=1 last=%0b data=%02h",
                             out_valid, out_last, out_data, prev[8], prev[7:0]);
                end
            end
            if (out_valid) out_ready = pattern[i % 4];
            prev_stall = out_valid && !out_ready;
            prev = {out_last, out_data};
            if (sb.size() == 0 && !out_valid) break;
        end
        out_ready = 1'b1;
        wait_drain(20, "bp");
        checks++;
        if (hs_cnt - base != 6) begin
            errors++;
            $display("FAIL bp_handshakes: got %0d handshakes, expected 6", hs_cnt - base);
        end
    endtask

    task automatic test_overflow();
        apply_reset();
        for (int i = 0; i < 10; i++) begin
            drive_sample(i[0], 8'(8'h30 + i), 32'hA5000000 + 32'(i));
            if (i < 5) push_frame(7'(i), i[0], 8'(8'h30 + i), 32'hA5000000 + 32'(i));
            tick();
        end
        idle_inputs();
        checks++;
        if (fifo_level !== 3'd4 || drop_cnt !== 8'd5 || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL overflow_state: level=%0d drop=%0d valid=%0b, expected level=4 drop=5 valid=1",
                     fifo_level, drop_cnt, out_valid);
        end
        out_ready = 1'b1;
        wait_drain(80, "overflow");
    endtask

    task automatic test_saturation();
        apply_reset();
        for (int i = 0; i < 310; i++) begin
            drive_sample(1'b0, 8'h77, 32'h11223344);
            if (i < 5) push_frame(7'(i), 1'b0, 8'h77, 32'h11223344);
            tick();
            if (i == 258) begin
                checks++;
                if (drop_cnt !== 8'd254) begin
                    errors++;
                    $display("FAIL sat_254: drop_cnt=%0d, expected 254", drop_cnt);
                end
            end
            if (i == 259 || i == 309) begin
                checks++;
                if (drop_cnt !== 8'd255) begin
                    errors++;
                    $display("FAIL sat_255: drop_cnt=%0d after %0d samples, expected 255", drop_cnt, i + 1);
                end
            end
        end
        idle_inputs();
        out_ready = 1'b1;
        wait_drain(80, "sat");
    endtask

    task automatic test_seq_wrap();
        apply_reset();
        out_ready = 1'b1;
        for (int k = 0; k < 130; k++) begin
            drive_sample(k[1], 8'(k), {4{8'(k)}});
            push_frame(7'(k), k[1], 8'(k), {4{8'(k)}});
            tick();
            idle_inputs();
            repeat (7) tick();
        end
        wait_drain(40, "wrap");
        checks++;
        if (drop_cnt !== 8'd0) begin
            errors++;
            $display("FAIL wrap_no_drop: drop_cnt=%0d, expected 0", drop_cnt);
        end
    endtask

    task automatic test_full_pop();
        int i;
        apply_reset();
        for (int k = 0; k < 5; k++) begin
            drive_sample(1'b1, 8'(8'hC0 + k), 32'hCAFE0000 + 32'(k));
            push_frame(7'(k), 1'b1, 8'(8'hC0 + k), 32'hCAFE0000 + 32'(k));
            tick();
        end
        idle_inputs();
        checks++;
        if (fifo_level !== 3'd4 || drop_cnt !== 8'd0) begin
            errors++;
            $display("FAIL fullpop_fill: level=%0d drop=%0d, expected level=4 drop=0", fifo_level, drop_cnt);
        end
        out_ready = 1'b1;
        for (i = 0; i < 20; i++) begin
            tick();
            if (!out_valid) break;
        end
        checks++;
        if (i == 20) begin
            errors++;
            $display("FAIL fullpop_idle: out_valid stayed 1 for 20 cycles, expected bubble");
        end
        drive_sample(1'b0, 8'hEE, 32'h0BADF00D);
        push_frame(7'd5, 1'b0, 8'hEE, 32'h0BADF00D);
        tick();
        idle_inputs();
        checks++;
        if (fifo_level !== 3'd4 || drop_cnt !== 8'd0) begin
            errors++;
            $display("FAIL fullpop_same_edge: level=%0d drop=%0d, expected level=4 drop=0", fifo_level, drop_cnt);
        end
        wait_drain(80, "fullpop");
    endtask

    task automatic test_reset_midframe();
        int i;
        int base;
        int seen;
        apply_reset();
        out_ready = 1'b1;
        base = hs_cnt;
        for (int k = 0; k < 3; k++) begin
            drive_sample(1'b1, 8'(k), 32'h12345678);
            push_frame(7'(k), 1'b1, 8'(k), 32'h12345678);
            tick();
        end
        idle_inputs();
        for (i = 0; i < 30; i++) begin
            if (hs_cnt - base == 3) break;
            tick();
        end
        checks++;
        if (i == 30 || fifo_level !== 3'd2) begin
            errors++;
            $display("FAIL midrst_setup: handshakes=%0d level=%0d, expected 3 and 2", hs_cnt - base, fifo_level);
        end
        #1 rst_n = 1'b0;
        sb.delete();
        #1;
        checks++;
        if (out_valid !== 1'b0 || fifo_level !== 3'd0 || out_data !== 8'h00) begin
            errors++;
            $display("FAIL midrst_async: valid=%0b level=%0d data=%02h, expected 0 0 00",
                     out_valid, fifo_level, out_data);
        end
        tick();
        rst_n = 1'b1;
        seen = 0;
        repeat (20) begin
            tick();
            if (out_valid) seen++;
        end
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL midrst_quiet: out_valid high %0d cycles after reset, expected 0", seen);
        end
        drive_sample(1'b0, 8'h55, 32'h01234567);
        push_frame(7'd0, 1'b0, 8'h55, 32'h01234567);
        tick();
        idle_inputs();
        wait_drain(40, "midrst");
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_single();
        test_backpressure();
        test_overflow();
        test_saturation();
        test_seq_wrap();
        test_full_pop();
        test_reset_midframe();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
